// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes, denomination values, dispenser states
// and item prices used by both the vending core and the change dispenser.
package vend_pkg;

  localparam logic [3:0] COIN_1  = 4'b0001;
  localparam logic [3:0] COIN_5  = 4'b0010;
  localparam logic [3:0] COIN_10 = 4'b0100;
  localparam logic [3:0] COIN_20 = 4'b1000;

  localparam logic [7:0] VAL_1  = 8'd1;
  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_20 = 8'd20;

  localparam logic [7:0] PRICE_A = 8'd3;
  localparam logic [7:0] PRICE_B = 8'd12;
  localparam logic [7:0] PRICE_C = 8'd20;
  localparam logic [7:0] PRICE_D = 8'd45;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2,
    FINISH = 2'd3
  } disp_state_t;

  // Greedy choice: largest coin that fits the remainder and is still in stock.
  function automatic logic [3:0] pick_coin(input logic [7:0] rem, input logic [3:0] avail);
    logic [3:0] c;
    c = 4'b0000;
    if (avail[3] && rem >= VAL_20)      c = COIN_20;
    else if (avail[2] && rem >= VAL_10) c = COIN_10;
    else if (avail[1] && rem >= VAL_5)  c = COIN_5;
    else if (avail[0] && rem >= VAL_1)  c = COIN_1;
    return c;
  endfunction

  function automatic logic [7:0] coin_value(input logic [3:0] c);
    logic [7:0] v;
    case (c)
      COIN_20: v = VAL_20;
      COIN_10: v = VAL_10;
      COIN_5:  v = VAL_5;
      COIN_1:  v = VAL_1;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_stock_bank.sv
// Per-denomination coin stock: parallel reload on reset/refill and a
// single-coin decrement selected by a one-hot denomination code.
module coin_stock_bank
  import vend_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int INIT_C20 = 16,
  parameter int INIT_C10 = 16,
  parameter int INIT_C5  = 32,
  parameter int INIT_C1  = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       reload,
  input  logic       dec,
  input  logic [3:0] dec_sel,
  output logic [3:0] nonzero
);

  logic [CNT_W-1:0] cnt [4];

  // Index order matches the one-hot coin bit positions: 1, 5, 10, 20.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt[0] <= CNT_W'(INIT_C1);
      cnt[1] <= CNT_W'(INIT_C5);
      cnt[2] <= CNT_W'(INIT_C10);
      cnt[3] <= CNT_W'(INIT_C20);
    end else if (reload) begin
      cnt[0] <= CNT_W'(INIT_C1);
      cnt[1] <= CNT_W'(INIT_C5);
      cnt[2] <= CNT_W'(INIT_C10);
      cnt[3] <= CNT_W'(INIT_C20);
    end else if (dec) begin
      for (int i = 0; i < 4; i++) begin
        if (dec_sel[i] && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    nonzero = 4'b0000;
    for (int i = 0; i < 4; i++) nonzero[i] = (cnt[i] != '0);
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount as a stream of greedy 20/10/5/1 coins over a
// valid/ready handshake, skipping empty denominations and flagging shortfalls.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int INIT_C20 = 16,
  parameter int INIT_C10 = 16,
  parameter int INIT_C5  = 32,
  parameter int INIT_C1  = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic [7:0] amount,
  input  logic       refill,
  input  logic       coin_ready,
  output logic       coin_valid,
  output logic [3:0] coin,
  output logic       busy,
  output logic       disp_done,
  output logic       short,
  output logic [7:0] remaining
);

  disp_state_t state;
  logic [7:0]  rem;
  logic [3:0]  nonzero;
  logic [3:0]  pick;
  logic        take;
  logic        reload;

  assign take   = (state == ISSUE) && coin_valid && coin_ready;
  assign reload = (state == IDLE) && refill && !req;
  assign pick   = pick_coin(rem, nonzero);

  coin_stock_bank #(
    .CNT_W   (CNT_W),
    .INIT_C20(INIT_C20),
    .INIT_C10(INIT_C10),
    .INIT_C5 (INIT_C5),
    .INIT_C1 (INIT_C1)
  ) u_bank (
    .clk    (clk),
    .reset_n(reset_n),
    .reload (reload),
    .dec    (take),
    .dec_sel(coin),
    .nonzero(nonzero)
  );

  // disp_done is raised on entry to FINISH so it is high exactly while FINISH lasts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rem        <= 8'd0;
      coin_valid <= 1'b0;
      coin       <= 4'b0000;
      busy       <= 1'b0;
      disp_done  <= 1'b0;
      short      <= 1'b0;
      remaining  <= 8'd0;
    end else begin
      disp_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            rem   <= amount;
            short <= 1'b0;
            busy  <= 1'b1;
            if (amount == 8'd0) begin
              state     <= FINISH;
              disp_done <= 1'b1;
            end else begin
              state <= SELECT;
            end
          end
        end
        SELECT: begin
          if (rem == 8'd0) begin
            state     <= FINISH;
            disp_done <= 1'b1;
          end else if (pick != 4'b0000) begin
            coin       <= pick;
            coin_valid <= 1'b1;
            state      <= ISSUE;
          end else begin
            short     <= 1'b1;
            remaining <= rem;
            state     <= FINISH;
            disp_done <= 1'b1;
          end
        end
        ISSUE: begin
          if (coin_ready) begin
            rem        <= rem - coin_value(coin);
            coin_valid <= 1'b0;
            coin       <= 4'b0000;
            state      <= SELECT;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
